// File: rtl/demux_ctrl_pkg.sv
// Shared definitions for the demux-side control blocks: the state encoding
// and the destination-count relation N = 2**n.
package demux_ctrl_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SEND = 1'b1;

  typedef enum logic {
    IDLE = ST_IDLE,
    SEND = ST_SEND
  } state_t;

  // Number of destinations addressed by an n-bit select.
  function automatic int num_dst(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/demux_1xN.sv
// 1-to-N demultiplexer: routes f onto output s when enabled, all other outputs low.
module demux_1xN
  import demux_ctrl_pkg::*;
#(
  parameter int n = 3
) (
  input  logic                    f,
  input  logic                    en,
  input  logic [n-1:0]            s,
  output logic [num_dst(n)-1:0]   y
);

  always_comb begin
    y = '0;
    if (en) begin
      y[s] = f;
    end
  end

endmodule

// File: rtl/rr_picker.sv
// Round-robin pick: first set mask bit at or after ptr, wrapping modulo N.
module rr_picker
  import demux_ctrl_pkg::*;
#(
  parameter int n = 3
) (
  input  logic [num_dst(n)-1:0] mask,
  input  logic [n-1:0]          ptr,
  output logic [n-1:0]          idx,
  output logic                  found
);

  localparam int N = num_dst(n);

  logic [n-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int j = N - 1; j >= 0; j--) begin
      cand = ptr + j[n-1:0];
      if (mask[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_rr_dispatcher.sv
// One-word buffer that hands each input word to the next eligible destination
// in round-robin order, driving the demux select/enable until it is accepted.
module demux_rr_dispatcher
  import demux_ctrl_pkg::*;
#(
  parameter int n = 3,
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [W-1:0]          in_data,
  output logic                  in_ready,
  input  logic [num_dst(n)-1:0] dst_mask,
  input  logic [num_dst(n)-1:0] out_ready,
  output logic [num_dst(n)-1:0] out_valid,
  output logic [W-1:0]          out_data,
  output logic [n-1:0]          sel,
  output logic                  busy
);

  state_t       state;
  state_t       state_next;
  logic [n-1:0] ptr;
  logic [n-1:0] sel_q;
  logic [W-1:0] data_q;
  logic [n-1:0] pick_idx;
  logic         pick_found;
  logic         load;
  logic         deliver;

  rr_picker #(.n(n)) u_picker (
    .mask  (dst_mask),
    .ptr   (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // An empty mask leaves nothing to pick, so the producer is stalled.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    load       = 1'b0;
    deliver    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = pick_found && !rst;
        load     = in_valid && pick_found;
        if (load) begin
          state_next = SEND;
        end
      end
      SEND: begin
        deliver = out_ready[sel_q];
        if (deliver) begin
          state_next = IDLE;
        end
      end
    endcase
  end

  // The mask is consulted only at capture; the chosen sel is held until delivery.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= '0;
      sel_q  <= '0;
      data_q <= '0;
    end else begin
      if (load) begin
        data_q <= in_data;
        sel_q  <= pick_idx;
      end
      if (deliver) begin
        ptr <= sel_q + 1'b1;
      end
    end
  end

  demux_1xN #(.n(n)) u_demux (
    .f  (1'b1),
    .en (state == ST_SEND),
    .s  (sel_q),
    .y  (out_valid)
  );

  assign busy     = (state == SEND);
  assign sel      = sel_q;
  assign out_data = data_q;

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Self-checking bench for demux_rr_dispatcher: directed scenarios plus random
// traffic compared every cycle against a transaction-level model.
module tb_demux_rr_dispatcher;

  localparam int NB = 3;
  localparam int N  = 8;
  localparam int W  = 8;

  typedef struct {
    int         dest;
    logic [7:0] data;
  } dlv_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic [N-1:0] dst_mask;
  logic [N-1:0] out_ready;
  logic [N-1:0] out_valid;
  logic [W-1:0] out_data;
  logic [NB-1:0] sel;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  bit         m_busy = 0;
  int         m_sel  = 0;
  int         m_ptr  = 0;
  logic [7:0] m_data = 8'h00;

  dlv_t log_q[$];

  demux_rr_dispatcher #(.n(NB), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .dst_mask  (dst_mask),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .sel       (sel),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Compare the DUT against the model and record any handshake it completes.
  task automatic checkOutput();
    logic [N-1:0] exp_valid;
    exp_valid = m_busy ? (N'(1) << m_sel) : '0;
    check("in_ready", 32'(in_ready), 32'(!rst && !m_busy && (dst_mask != 0)));
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    check("busy", 32'(busy), 32'(m_busy));
    check("sel", 32'(sel), 32'(m_sel));
    check("out_data", 32'(out_data), 32'(m_data));
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (out_valid[i] && out_ready[i]) log_q.push_back('{dest: i, data: out_data});
      end
    end
  endtask

  // Advance the model by the edge that ends this cycle.
  task automatic updateModel();
    if (rst) begin
      m_busy = 0; m_sel = 0; m_ptr = 0; m_data = 8'h00;
    end else if (!m_busy) begin
      if (in_valid && dst_mask != 0) begin
        for (int k = N - 1; k >= 0; k--) begin
          if (dst_mask[(m_ptr + k) % N]) m_sel = (m_ptr + k) % N;
        end
        m_data = in_data;
        m_busy = 1;
      end
    end else if (out_ready[m_sel]) begin
      m_ptr  = (m_sel + 1) % N;
      m_busy = 0;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic iv, input logic [7:0] d,
                               input logic [7:0] m, input logic [7:0] ordy);
    @(negedge clk);
    rst = r; in_valid = iv; in_data = d; dst_mask = m; out_ready = ordy;
    #1;
    checkOutput();
    updateModel();
    @(posedge clk);
    #1;
  endtask

  task automatic checkLog(input string name, input int idx, input int dest, input logic [7:0] data);
    if (idx < log_q.size()) begin
      check({name, "_dest"}, 32'(log_q[idx].dest), 32'(dest));
      check({name, "_data"}, 32'(log_q[idx].data), 32'(data));
    end else begin
      check({name, "_present"}, 32'(log_q.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    logic [7:0] rm;
    @(negedge clk);
    rst = 1; in_valid = 0; in_data = 0; dst_mask = 0; out_ready = 0;
    @(posedge clk);
    #1;
    applyStimulus(1, 0, 8'h00, 8'h00, 8'h00);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_sel", 32'(sel), 32'h0);
    check("reset_out_data", 32'(out_data), 32'h0);
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_in_ready", 32'(in_ready), 32'h0);

    log_q.delete();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, 8'(8'h11 + i), 8'hFF, 8'hFF);
      check("stream_valid_after_capture", 32'(out_valid), 32'(8'h01 << i));
      applyStimulus(0, 1, 8'(8'h11 + i), 8'hFF, 8'hFF);
    end
    for (int i = 0; i < 8; i++) checkLog("stream", i, i, 8'(8'h11 + i));

    log_q.delete();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 8'(8'h21 + i), 8'b1000_0101, 8'hFF);
      applyStimulus(0, 0, 8'h00, 8'b1000_0101, 8'hFF);
    end
    checkLog("sparse0", 0, 0, 8'h21);
    checkLog("sparse1", 1, 2, 8'h22);
    checkLog("sparse2", 2, 7, 8'h23);
    checkLog("sparse3", 3, 0, 8'h24);

    log_q.delete();
    applyStimulus(0, 1, 8'hA5, 8'hFF, 8'h00);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 8'h5A, 8'hFF, 8'hFD);
      check("stall_out_valid", 32'(out_valid), 32'h02);
      check("stall_sel", 32'(sel), 32'h1);
      check("stall_out_data", 32'(out_data), 32'hA5);
      check("stall_in_ready", 32'(in_ready), 32'h0);
    end
    applyStimulus(0, 0, 8'h00, 8'hFF, 8'h02);
    check("stall_log_size", 32'(log_q.size()), 32'h1);
    checkLog("stall", 0, 1, 8'hA5);

    log_q.delete();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 8'h77, 8'h00, 8'hFF);
      check("empty_busy", 32'(busy), 32'h0);
    end
    applyStimulus(0, 1, 8'h77, 8'h10, 8'hFF);
    applyStimulus(0, 0, 8'h00, 8'h10, 8'hFF);
    checkLog("mask10", 0, 4, 8'h77);

    log_q.delete();
    applyStimulus(0, 1, 8'h3C, 8'hFF, 8'h00);
    applyStimulus(0, 0, 8'h00, 8'hDF, 8'hFF);
    checkLog("maskchange", 0, 5, 8'h3C);

    log_q.delete();
    applyStimulus(0, 1, 8'hC3, 8'hFF, 8'h00);
    check("midsend_busy", 32'(busy), 32'h1);
    applyStimulus(1, 0, 8'h00, 8'hFF, 8'h00);
    check("midsend_rst_busy", 32'(busy), 32'h0);
    check("midsend_rst_sel", 32'(sel), 32'h0);
    check("midsend_rst_data", 32'(out_data), 32'h0);
    check("midsend_rst_valid", 32'(out_valid), 32'h0);
    applyStimulus(0, 1, 8'h99, 8'hFF, 8'h00);
    applyStimulus(0, 0, 8'h00, 8'hFF, 8'hFF);
    check("midsend_log_size", 32'(log_q.size()), 32'h1);
    checkLog("after_rst", 0, 0, 8'h99);

    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 3))
        0: rm = 8'h00;
        1: rm = 8'h01 << $urandom_range(0, 7);
        default: rm = 8'($urandom);
      endcase
      applyStimulus(($urandom_range(0, 63) == 0), 1'($urandom), 8'($urandom), rm, 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_rr_dispatcher.md
# demux_rr_dispatcher

Round-robin dispatcher that feeds one input word stream to N = 2**n destination channels through a 1-to-N demultiplexer. It buffers one word, picks the next enabled destination in round-robin order, and drives the demux select/enable until that destination accepts. It sits in front of the demux, between a single producer and N consumers that use valid/ready handshakes.

## Interface
- n, 3, select width; N = 2**n destinations
- W, 8, data word width

- clk  input  1  rising-edge clock (single clock domain)
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  producer has a word
- in_data  input  W  producer word
- in_ready  output  1  dispatcher accepts the word this cycle
- dst_mask  input  N  bit i = 1: destination i eligible for selection
- out_ready  input  N  destination i accepts out_data this cycle
- out_valid  output  N  one-hot (or zero) valid to destinations
- out_data  output  W  buffered word, shared by all destinations
- sel  output  n  current demux select (valid when busy)
- busy  output  1  word held, awaiting delivery

## Operation
- Two states: IDLE (buffer empty) and SEND (buffer full).
- IDLE: in_ready = (dst_mask != 0). If in_valid && in_ready:
  - capture in_data into out_data.
  - sel <= first index i with dst_mask[i] = 1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (modulo N).
  - go to SEND.
- SEND: in_ready = 0, busy = 1. out_valid[sel] = 1, all other bits 0. If out_ready[sel] = 1:
  - ptr <= sel + 1 (n-bit wrap; N-1 wraps to 0).
  - go to IDLE.
- out_ready bits other than sel are ignored.
- dst_mask is sampled only at capture. Clearing dst_mask[sel] during SEND does not cancel delivery; the word is still delivered to sel.
- dst_mask == 0 in IDLE: in_ready = 0, the producer stalls, and state holds.
- out_data holds its value after delivery until the next capture.
- Reset (any cycle, including mid-SEND) discards the buffered word. On the next edge: state = IDLE, ptr = 0, sel = 0, out_data = 0, busy = 0, out_valid = 0. While rst = 1, in_ready = 0.

## Timing
- in_ready and out_valid are combinational from state, sel and dst_mask. There is no combinational path from in_valid to in_ready or from out_ready to out_valid.
- Capture at edge t. out_valid[sel] is asserted in cycle t+1. If out_ready[sel] is high in cycle t+1, delivery completes at edge t+1 and the next capture can occur at edge t+2.
- Maximum throughput: one word per 2 cycles.
- Back-pressure: SEND holds indefinitely; out_data and sel stay stable while out_valid is high.
- Single enabled destination k: every word goes to k, and ptr ends at k+1 mod N after each word.

## Structure
- Shared package demux_ctrl_pkg holds:
  - state encoding localparams ST_IDLE = 1'b0 and ST_SEND = 1'b1.
  - the N = 2**n relation as a function or macro, used by all demux-side blocks.
- Sub-module rr_picker (parameter n): inputs mask[N] and ptr[n]; outputs idx[n] and found. Purely combinational rotate-and-priority-encode.
- out_valid decode instantiates the existing demux_1xN with f = 1'b1, en = (state == ST_SEND), s = sel.

## Test plan
- Reset then stream: n=3, dst_mask = 8'hFF, send 0x11..0x18 with all out_ready = 1 → words land on destinations 0..7 in order, each out_valid one cycle after capture, in_ready toggling 1/0.
- Sparse mask with wrap: dst_mask = 8'b1000_0101, send 4 words → destinations 0, 2, 7, 0; ptr wraps from 7 to 0.
- Back-pressure: out_ready[sel] = 0 for 5 cycles → out_valid, out_data and sel stable; in_ready = 0 throughout; delivery on cycle 6.
- Empty mask: dst_mask = 0 with in_valid = 1 → in_ready = 0, no capture; set dst_mask = 8'h10 → next word to destination 4.
- Mask change mid-SEND: clear dst_mask[sel] during SEND → word still delivered to the original sel.
- Reset mid-SEND: assert rst with busy = 1 → next cycle out_valid = 0, busy = 0, sel = 0, out_data = 0; the next word goes to destination 0.
